// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Also provides a wide reference sum for checking results.
package adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } add_state_e;

    localparam int unsigned DefaultWidth = 8;

    // Bit 64 carries the carry-out; callers slice what they need.
    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + {64'd0, cin};
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder with every input combination decoded.
module fa_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    always_comb begin
        o_s  = 1'b0;
        o_co = 1'b0;
        case ({i_x, i_y, i_ci})
            3'b000: begin o_s = 1'b0; o_co = 1'b0; end
            3'b001: begin o_s = 1'b1; o_co = 1'b0; end
            3'b010: begin o_s = 1'b1; o_co = 1'b0; end
            3'b011: begin o_s = 1'b0; o_co = 1'b1; end
            3'b100: begin o_s = 1'b1; o_co = 1'b0; end
            3'b101: begin o_s = 1'b0; o_co = 1'b1; end
            3'b110: begin o_s = 1'b0; o_co = 1'b1; end
            3'b111: begin o_s = 1'b1; o_co = 1'b1; end
            default: begin o_s = 1'b0; o_co = 1'b0; end
        endcase
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks the operands LSB to MSB,
// with valid/ready handshakes on both the operand and result sides.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter  int unsigned WIDTH = DefaultWidth,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    add_state_e       r_state;
    add_state_e       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_c;

    fa_cell u_fa_cell (
        .i_x  (r_a[0]),
        .i_y  (r_b[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle: if (i_in_valid) w_next_state = StRun;
            StRun:  if (r_cnt == LastCnt) w_next_state = StDone;
            StDone: if (i_out_ready) w_next_state = StIdle;
            default: w_next_state = StIdle;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == StIdle);
        o_out_valid = (r_state == StDone);
        o_busy      = (r_state == StRun) || (r_state == StDone);
    end

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                    end
                end
                StRun: begin
                    r_s     <= {w_s, r_s[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= (r_cnt == LastCnt) ? '0 : r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_sum  = r_s;
    assign o_cout = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed checks of serial_add_ctrl against a plain-arithmetic model.
module tb_serial_add_ctrl;
    import adder_pkg::*;

    localparam int W = 8;
    localparam int NumSoak = 1000;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_sum       (sum),
        .o_cout      (cout),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
        logic [64:0] r;
        r = ref_add({56'd0, x}, {56'd0, y}, c);
        return r[8:0];
    endfunction

    // Returns #1 after the accepting clock edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int   guard;
        logic seen;
        @(negedge clk);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        guard = 0;
        seen  = in_ready;
        while (!seen && guard < 200) begin
            @(negedge clk);
            guard++;
            seen = in_ready;
        end
        if (!seen) check("send_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [8:0] exp);
        int   guard;
        logic seen;
        guard = 0;
        @(negedge clk);
        seen = out_valid;
        while (!seen && guard < 50) begin
            @(negedge clk);
            guard++;
            seen = out_valid;
        end
        if (!seen) check({tag, "_timeout"}, 32'(seen), 32'd1);
        check(tag, 32'({cout, sum}), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    logic [8:0] exp_q[$];
    logic [8:0] held;
    int         cons_cnt;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'({cout, sum}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic add with latency: valid only after edge k+W.
        send(8'h3C, 8'h0F, 1'b0);
        check("run_busy", 32'(busy), 32'd1);
        check("run_in_ready", 32'(in_ready), 32'd0);
        repeat (W - 1) @(posedge clk);
        #1 check("latency_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 check("latency_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        recv("basic_add", 9'h04B);

        send(8'hFF, 8'hFF, 1'b1);
        recv("ripple_ff_ff_1", 9'h1FF);

        // Carry ripple under backpressure.
        send(8'hFF, 8'h01, 1'b0);
        repeat (W) @(posedge clk);
        @(negedge clk);
        check("bp_valid0", 32'(out_valid), 32'd1);
        check("bp_ripple", 32'({cout, sum}), 32'h100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_value", 32'({cout, sum}), 32'h100);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // in_valid pulsed during RUN must be ignored.
        send(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        a = 8'h11; b = 8'h22; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("busy_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        recv("busy_first", 9'h046);
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            check("busy_no_extra", 32'(out_valid), 32'd0);
        end

        // Reset at cnt==3 discards the partial result immediately.
        send(8'h55, 8'hAA, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sum", 32'({cout, sum}), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h80, 8'h80, 1'b0);
        recv("post_rst_add", 9'h100);

        // Random soak with concurrent producer and stalling consumer.
        cons_cnt = 0;
        fork
            begin
                for (int i = 0; i < NumSoak; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    logic         rc;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom);
                    send(ra, rb, rc);
                    exp_q.push_back(model(ra, rb, rc));
                end
            end
            begin
                int   guard;
                logic prev_hold;
                guard     = 0;
                prev_hold = 1'b0;
                while (cons_cnt < NumSoak && guard < 60000) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid) begin
                        if (prev_hold) check("soak_stable", 32'({cout, sum}), 32'(held));
                        held = {cout, sum};
                        if ($urandom_range(0, 2) == 0) begin
                            if (exp_q.size() == 0) begin
                                check("soak_dup", 32'(exp_q.size()), 32'd1);
                            end else begin
                                check("soak_sum", 32'({cout, sum}), 32'(exp_q.pop_front()));
                            end
                            cons_cnt++;
                            out_ready = 1'b1;
                            prev_hold = 1'b0;
                        end else begin
                            out_ready = 1'b0;
                            prev_hold = 1'b1;
                        end
                    end else begin
                        out_ready = 1'b0;
                        prev_hold = 1'b0;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
                check("soak_count", 32'(cons_cnt), 32'(NumSoak));
            end
        join
        check("soak_leftover", 32'(exp_q.size()), 32'd0);
        repeat (W + 3) @(negedge clk);
        check("soak_idle_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that shares a single 1-bit full-adder cell across an N-bit addition, processing one bit per clock from the LSB to the MSB.
- Accepts operand pairs over a valid/ready input handshake.
- Returns sum and carry-out over a valid/ready output handshake.
- Sits between an operand producer and a result consumer, replacing a wide ripple adder where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range WIDTH >= 2).
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
in_valid  input  1  producer presents a, b, cin.
in_ready  output  1  controller can accept an operand pair.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum and cout are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result, a+b+cin modulo 2^WIDTH.
cout  output  1  carry-out of bit WIDTH-1.
busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; operand shift registers, sum register, carry flop and counter all cleared.
  - Reset outputs: out_valid=0, busy=0, sum=0, cout=0, in_ready=1.
  - Inputs are ignored while rst_n is low.
- State machine (3 states):
  - IDLE:
    - in_ready=1.
    - On in_valid && in_ready: load A<=a, B<=b, carry<=cin, cnt<=0 -> RUN.
  - RUN:
    - in_ready=0, busy=1.
    - Every cycle: the fa_cell computes s/c from A[0], B[0], carry.
    - Updates: S <= {s, S[WIDTH-1:1]}; A and B shift right by 1; carry <= c; cnt <= cnt+1.
    - When cnt==WIDTH-1: the final bit is written -> DONE.
  - DONE:
    - out_valid=1; sum=S and cout=carry are held stable.
    - On out_ready: -> IDLE. out_valid drops in the next cycle.
- Latency:
  - Operand accepted at edge k; out_valid is high after edge k+WIDTH.
  - Exactly WIDTH cycles are spent in RUN.
  - Minimum initiation interval is WIDTH+2 cycles (IDLE, RUN x WIDTH, DONE).
- Handshake rules:
  - in_valid is ignored outside IDLE; the producer must hold a/b/cin until in_ready is seen.
  - out_valid, once high, stays high with unchanged sum/cout until out_ready is sampled high (no retraction).
  - in_ready and out_valid are never high in the same cycle.
- Output values:
  - sum/cout are registered, with no combinational path from inputs.
  - Values while out_valid=0 are don't-care: partial results are visible during RUN.
- Arithmetic:
  - The sum is exact modulo 2^WIDTH; cout is the true carry.
  - All 8 input combinations of the fa_cell are explicitly decoded, so no latch or unspecified output is possible.
- Boundary conditions:
  - cnt wraps: it is compared against WIDTH-1 and never exceeds it.
  - For a non-power-of-two WIDTH, unused counter codes are unreachable.
  - Unreachable FSM encodings recover to IDLE.
- Reset mid-operation (RUN or DONE): the in-flight result is discarded with no out_valid pulse; the controller returns to IDLE within the same reset assertion.
- Simultaneous events: out_ready asserted in the same cycle DONE is entered has no effect until DONE is registered. The handshake completes on the first edge where state==DONE and out_ready=1.

Decomposition:
- Package adder_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - default WIDTH constant;
  - a function computing the reference a+b+cin, for use by the bench.
- Sub-module fa_cell: combinational 1-bit full adder.
  - Inputs x, y, ci; outputs s, co.
  - Every case is covered, plus a default arm.
  - Instantiated once in serial_add_ctrl.

Test Plan:
- Basic add (WIDTH=8): a=0x3C, b=0x0F, cin=0 -> out_valid 8 cycles after acceptance; sum=0x4B, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum/cout are unchanged. Raise out_ready -> IDLE next cycle, in_ready=1.
- Input ignored while busy: pulse in_valid with a=0x11, b=0x22 during RUN -> no effect, first result is correct, in_ready stays 0 until IDLE.
- Reset mid-run: deassert rst_n at RUN cnt=3 -> immediately out_valid=0, busy=0, sum=0. After release, a new add of 0x80+0x80 -> sum=0x00, cout=1.
- Random soak: 1000 back-to-back operand pairs with random out_ready stalls -> every result equals the adder_pkg reference, with no lost or duplicated transactions.
